// File: rtl/switch_cfg_reg_bank.sv
//==============================================================================
// Module      : switch_cfg_reg_bank
// Description : Configuration register bank for the chiplet switch. Holds the
//               per-outport dateline bits and the route lookup table, serves
//               round-robin arbitrated read/write requests from NUM_BUFFERS
//               ingress channels (one per cycle) and returns a registered
//               response with error status.
//               Optional build macro SWITCH_CFG_REG_BANK_LOCK_EN adds a sticky
//               write lock in control register bit 1.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module switch_cfg_reg_bank #(
   parameter  int NUM_BUFFERS  = 4,
   parameter  int NUM_OUTPORTS = 4,
   parameter  int TOTAL_NODES  = 8,
   parameter  int TABLE_SIZE   = 8,
   parameter  int DATA_W       = 32,
   localparam int NODE_W       = $clog2(TOTAL_NODES),
   localparam int PORT_W       = $clog2(NUM_OUTPORTS),
   localparam int ADDR_W       = $clog2(TABLE_SIZE + 2),
   localparam int CH_W         = $clog2(NUM_BUFFERS)
) (
   input  logic                          clk,
   input  logic                          n_rst,
   input  logic [NUM_BUFFERS-1:0]        cfg_valid,
   input  logic [NUM_BUFFERS-1:0]        cfg_we,
   input  logic [NUM_BUFFERS*ADDR_W-1:0] cfg_addr,
   input  logic [NUM_BUFFERS*DATA_W-1:0] cfg_wdata,
   output logic [NUM_BUFFERS-1:0]        cfg_ready,
   output logic                          rsp_valid,
   output logic [CH_W-1:0]               rsp_chan,
   output logic                          rsp_err,
   output logic [DATA_W-1:0]             rsp_rdata,
   input  logic                          rsp_ready,
   output logic [NUM_OUTPORTS-1:0]       dateline,
   output logic [TABLE_SIZE-1:0]         lut_valid,
   output logic [TABLE_SIZE*NODE_W-1:0]  lut_node,
   output logic [TABLE_SIZE*PORT_W-1:0]  lut_port
);

   localparam int LUT_IW  = (TABLE_SIZE > 1) ? $clog2(TABLE_SIZE) : 1;
   localparam int NODE_CW = NODE_W + 1;
   localparam int PORT_CW = PORT_W + 1;

   localparam logic [ADDR_W-1:0]  C_ADDR_LUT_LAST = ADDR_W'(TABLE_SIZE);
   localparam logic [ADDR_W-1:0]  C_ADDR_CTRL     = ADDR_W'(TABLE_SIZE + 1);
   localparam logic [NODE_CW-1:0] C_NODE_LIMIT    = NODE_CW'(TOTAL_NODES);
   localparam logic [PORT_CW-1:0] C_PORT_LIMIT    = PORT_CW'(NUM_OUTPORTS);
   localparam logic [CH_W-1:0]    C_LAST_CH       = CH_W'(NUM_BUFFERS - 1);

   logic [CH_W-1:0]         r_ptr;
   logic                    r_rsp_valid;
   logic [CH_W-1:0]         r_rsp_chan;
   logic                    r_rsp_err;
   logic [DATA_W-1:0]       r_rsp_rdata;
   logic [NUM_OUTPORTS-1:0] r_dateline;
   logic [TABLE_SIZE-1:0]   r_lut_valid;
   logic [NODE_W-1:0]       r_lut_node [TABLE_SIZE];
   logic [PORT_W-1:0]       r_lut_port [TABLE_SIZE];

   logic                    w_gnt_found;
   logic [CH_W-1:0]         w_gnt_idx;
   logic [CH_W-1:0]         w_cand;
   logic                    w_can_accept;
   logic                    w_accept;
   logic                    w_sel_we;
   logic [ADDR_W-1:0]       w_sel_addr;
   logic [DATA_W-1:0]       w_sel_wdata;
   logic [LUT_IW-1:0]       w_lut_idx;
   logic [NODE_W-1:0]       w_wnode;
   logic [PORT_W-1:0]       w_wport;
   logic                    w_wvld;
   logic                    w_is_dl;
   logic                    w_is_lut;
   logic                    w_is_ctrl;
   logic                    w_bad_addr;
   logic                    w_lut_bad;
   logic                    w_locked;
   logic                    w_err;
   logic                    w_do_write;
   logic [DATA_W-1:0]       w_rdata;
   logic                    w_unused;

   // Round-robin search starting at the pointer, wrapping upward; idle channels cost nothing
   always_comb begin
      w_gnt_found = 1'b0;
      w_gnt_idx   = '0;
      w_cand      = '0;
      for (int k = 0; k < NUM_BUFFERS; k++) begin
         w_cand = CH_W'((int'(r_ptr) + k) % NUM_BUFFERS);
         if (!w_gnt_found && cfg_valid[w_cand]) begin
            w_gnt_found = 1'b1;
            w_gnt_idx   = w_cand;
         end
      end
   end

   // Accept depends only on the response register and rsp_ready, never on cfg_valid
   assign w_can_accept = !r_rsp_valid || rsp_ready;
   assign w_accept     = w_can_accept && w_gnt_found;

   // One-hot ready for the granted channel and mux of its request fields
   always_comb begin
      cfg_ready   = '0;
      w_sel_we    = 1'b0;
      w_sel_addr  = '0;
      w_sel_wdata = '0;
      if (w_accept) cfg_ready[w_gnt_idx] = 1'b1;
      for (int i = 0; i < NUM_BUFFERS; i++) begin
         if (w_gnt_idx == CH_W'(i)) begin
            w_sel_we    = cfg_we[i];
            w_sel_addr  = cfg_addr[i*ADDR_W +: ADDR_W];
            w_sel_wdata = cfg_wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   assign w_lut_idx  = LUT_IW'(w_sel_addr - 1'b1);
   assign w_wnode    = w_sel_wdata[NODE_W-1:0];
   assign w_wport    = w_sel_wdata[NODE_W+PORT_W-1:NODE_W];
   assign w_wvld     = w_sel_wdata[DATA_W-1];
   assign w_is_dl    = (w_sel_addr == '0);
   assign w_is_lut   = (w_sel_addr != '0) && (w_sel_addr <= C_ADDR_LUT_LAST);
   assign w_is_ctrl  = (w_sel_addr == C_ADDR_CTRL);
   assign w_bad_addr = (w_sel_addr > C_ADDR_CTRL);
   // A valid entry must point at a real outport and a real node
   assign w_lut_bad  = w_wvld && (({1'b0, w_wport} >= C_PORT_LIMIT) ||
                                  ({1'b0, w_wnode} >= C_NODE_LIMIT));
   assign w_err      = w_bad_addr || (w_sel_we && (w_locked || (w_is_lut && w_lut_bad)));
   assign w_do_write = w_accept && w_sel_we && !w_err;
   assign w_unused   = &{1'b0, w_sel_wdata};

`ifdef SWITCH_CFG_REG_BANK_LOCK_EN
   logic r_lock;

   // Sticky write lock, cleared only by reset
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)                                        r_lock <= 1'b0;
      else if (w_do_write && w_is_ctrl && w_sel_wdata[1]) r_lock <= 1'b1;
   end

   assign w_locked = r_lock;
`else
   assign w_locked = 1'b0;
`endif

   // Readback of the addressed register with unused bits forced to zero
   always_comb begin
      w_rdata = '0;
      if (w_is_dl) begin
         w_rdata[NUM_OUTPORTS-1:0] = r_dateline;
      end else if (w_is_lut) begin
         w_rdata[DATA_W-1]                 = r_lut_valid[w_lut_idx];
         w_rdata[NODE_W+PORT_W-1:NODE_W]   = r_lut_port[w_lut_idx];
         w_rdata[NODE_W-1:0]               = r_lut_node[w_lut_idx];
      end
`ifdef SWITCH_CFG_REG_BANK_LOCK_EN
      if (w_is_ctrl) w_rdata[1] = r_lock;
`endif
   end

   // Configuration state: writes land on the accepting edge
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_dateline  <= '0;
         r_lut_valid <= '0;
         for (int e = 0; e < TABLE_SIZE; e++) begin
            r_lut_node[e] <= '0;
            r_lut_port[e] <= '0;
         end
      end else if (w_do_write) begin
         if (w_is_dl) r_dateline <= w_sel_wdata[NUM_OUTPORTS-1:0];
         if (w_is_lut) begin
            r_lut_valid[w_lut_idx] <= w_wvld;
            r_lut_node[w_lut_idx]  <= w_wnode;
            r_lut_port[w_lut_idx]  <= w_wport;
         end
         if (w_is_ctrl && w_sel_wdata[0]) begin
            r_lut_valid <= '0;
            r_dateline  <= '0;
         end
      end
   end

   // Response register and round-robin pointer; a new accept may replace a consumed response
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_ptr       <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_chan  <= '0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
      end else if (w_accept) begin
         r_ptr       <= (w_gnt_idx == C_LAST_CH) ? '0 : w_gnt_idx + 1'b1;
         r_rsp_valid <= 1'b1;
         r_rsp_chan  <= w_gnt_idx;
         r_rsp_err   <= w_err;
         r_rsp_rdata <= (w_sel_we || w_err) ? '0 : w_rdata;
      end else if (rsp_ready) begin
         r_rsp_valid <= 1'b0;
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_chan  = r_rsp_chan;
   assign rsp_err   = r_rsp_err;
   assign rsp_rdata = r_rsp_rdata;
   assign dateline  = r_dateline;
   assign lut_valid = r_lut_valid;

   generate
      for (genvar g = 0; g < TABLE_SIZE; g++) begin : g_lut_out
         assign lut_node[g*NODE_W +: NODE_W] = r_lut_node[g];
         assign lut_port[g*PORT_W +: PORT_W] = r_lut_port[g];
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_switch_cfg_reg_bank.sv
//==============================================================================
// Module      : tb_switch_cfg_reg_bank
// Description : Self-checking bench for switch_cfg_reg_bank. Stimulus pushes the
//               expected response into a queue; a monitor pops and compares
//               whenever a response is consumed. A second instance with three
//               outports and six nodes exercises the LUT field range errors.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_switch_cfg_reg_bank;

   localparam int NB = 4;
   localparam int NO = 4;
   localparam int TS = 8;
   localparam int DW = 32;
   localparam int AW = 4;
   localparam int CW = 2;
   localparam int NW = 3;
   localparam int PW = 2;
`ifdef SWITCH_CFG_REG_BANK_LOCK_EN
   localparam bit L = 1'b1;
`else
   localparam bit L = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              n_rst;
   logic [NB-1:0]     cfg_valid, cfg_we, cfg_ready;
   logic [NB*AW-1:0]  cfg_addr;
   logic [NB*DW-1:0]  cfg_wdata;
   logic              rsp_valid, rsp_err, rsp_ready;
   logic [CW-1:0]     rsp_chan;
   logic [DW-1:0]     rsp_rdata;
   logic [NO-1:0]     dateline;
   logic [TS-1:0]     lut_valid;
   logic [TS*NW-1:0]  lut_node;
   logic [TS*PW-1:0]  lut_port;

   // Second instance: NUM_OUTPORTS=3, TOTAL_NODES=6
   logic [NB-1:0]     d3_cfg_valid, d3_cfg_we, d3_cfg_ready;
   logic [NB*AW-1:0]  d3_cfg_addr;
   logic [NB*DW-1:0]  d3_cfg_wdata;
   logic              d3_rsp_valid, d3_rsp_err;
   logic              d3_rsp_ready;
   logic [CW-1:0]     d3_rsp_chan;
   logic [DW-1:0]     d3_rsp_rdata;
   logic [2:0]        d3_dateline;
   logic [TS-1:0]     d3_lut_valid;
   logic [TS*NW-1:0]  d3_lut_node;
   logic [TS*PW-1:0]  d3_lut_port;

   switch_cfg_reg_bank u_dut (
      .clk(clk), .n_rst(n_rst),
      .cfg_valid(cfg_valid), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .cfg_ready(cfg_ready),
      .rsp_valid(rsp_valid), .rsp_chan(rsp_chan), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
      .rsp_ready(rsp_ready),
      .dateline(dateline), .lut_valid(lut_valid), .lut_node(lut_node), .lut_port(lut_port)
   );

   switch_cfg_reg_bank #(.NUM_OUTPORTS(3), .TOTAL_NODES(6)) u_dut3 (
      .clk(clk), .n_rst(n_rst),
      .cfg_valid(d3_cfg_valid), .cfg_we(d3_cfg_we), .cfg_addr(d3_cfg_addr), .cfg_wdata(d3_cfg_wdata),
      .cfg_ready(d3_cfg_ready),
      .rsp_valid(d3_rsp_valid), .rsp_chan(d3_rsp_chan), .rsp_err(d3_rsp_err), .rsp_rdata(d3_rsp_rdata),
      .rsp_ready(d3_rsp_ready),
      .dateline(d3_dateline), .lut_valid(d3_lut_valid), .lut_node(d3_lut_node), .lut_port(d3_lut_port)
   );

   typedef struct packed {
      logic [CW-1:0] chan;
      logic          err;
      logic [DW-1:0] rdata;
   } rsp_t;

   rsp_t exp_q[$];
   int   n_checks = 0;
   int   n_errs   = 0;
   int   rr_ch;
   logic rr_err [NB];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input int ch, input logic e_err, input logic [DW-1:0] e_rd);
      rsp_t e;
      e.chan  = CW'(ch);
      e.err   = e_err;
      e.rdata = e_rd;
      exp_q.push_back(e);
   endtask

   // Monitor: a response is consumed when valid and ready are both high
   always @(negedge clk) begin
      if (n_rst && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errs++;
            $display("FAIL rsp_unexpected: got chan=%0d err=%b rdata=0x%0h, required none", rsp_chan, rsp_err, rsp_rdata);
         end else begin
            rsp_t e;
            e = exp_q.pop_front();
            check("rsp_chan", rsp_chan, e.chan);
            check("rsp_err", rsp_err, e.err);
            check("rsp_rdata", rsp_rdata, e.rdata);
         end
      end
   end

   task automatic drive(input int ch, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
      cfg_valid[ch]           = 1'b1;
      cfg_we[ch]              = we;
      cfg_addr[ch*AW +: AW]   = addr;
      cfg_wdata[ch*DW +: DW]  = wd;
   endtask

   // Issue one request, wait (bounded) for its accept, record the expected response
   task automatic req(input int ch, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                      input logic e_err, input logic [DW-1:0] e_rd);
      bit got;
      got = 1'b0;
      drive(ch, we, addr, wd);
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         if (cfg_ready[ch] === 1'b1) got = 1'b1;
      end
      if (!got) begin
         n_checks++;
         n_errs++;
         $display("FAIL accept_ch%0d: cfg_ready=%b, required bit %0d high within 20 cycles", ch, cfg_ready, ch);
      end else begin
         check("ready_onehot", cfg_ready, 64'(1 << ch));
         push_exp(ch, e_err, e_rd);
      end
      @(posedge clk);
      #1;
      cfg_valid[ch] = 1'b0;
   endtask

   task automatic drain();
      for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(posedge clk);
      #1;
      check("drain_empty", 64'(exp_q.size()), 0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3;
      n_rst = 1'b0;
      #1;
      check("async_rst_dateline", dateline, 0);
      check("async_rst_rspv", rsp_valid, 0);
      exp_q.delete();
      @(posedge clk);
      #1;
      n_rst = 1'b1;
   endtask

   task automatic d3_req(input string nm, input logic [DW-1:0] wd, input logic e_err);
      d3_cfg_valid = 4'b0001;
      d3_cfg_we    = 4'b0001;
      d3_cfg_addr  = 16'h0001;
      d3_cfg_wdata = {96'b0, wd};
      @(negedge clk);
      check({nm, "_ready"}, d3_cfg_ready, 4'b0001);
      @(posedge clk);
      #1;
      d3_cfg_valid = '0;
      @(negedge clk);
      check({nm, "_rspv"}, d3_rsp_valid, 1);
      check({nm, "_err"}, d3_rsp_err, e_err);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: time limit reached, required $finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      n_rst        = 1'b0;
      cfg_valid    = '0;
      cfg_we       = '0;
      cfg_addr     = '0;
      cfg_wdata    = '0;
      rsp_ready    = 1'b1;
      d3_cfg_valid = '0;
      d3_cfg_we    = '0;
      d3_cfg_addr  = '0;
      d3_cfg_wdata = '0;
      d3_rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_rst = 1'b1;
      @(negedge clk);
      check("rst_dateline", dateline, 0);
      check("rst_lut_valid", lut_valid, 0);
      check("rst_lut_node", lut_node, 0);
      check("rst_lut_port", lut_port, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_rdata", rsp_rdata, 0);
      @(posedge clk);
      #1;

      // Round robin: all channels valid, grants 0,1,2,3,0 back to back
      drive(0, 1'b0, 4'd1,  32'h0);
      drive(1, 1'b0, 4'd9,  32'h0);
      drive(2, 1'b0, 4'd12, 32'h0);
      drive(3, 1'b1, 4'd0,  32'hA);
      rr_err[0] = 1'b0; rr_err[1] = 1'b0; rr_err[2] = 1'b1; rr_err[3] = 1'b0;
      for (int k = 0; k < 5; k++) begin
         rr_ch = k % NB;
         @(negedge clk);
         check("rr_grant", cfg_ready, 64'(1 << rr_ch));
         push_exp(rr_ch, rr_err[rr_ch], 32'h0);
         @(posedge clk);
         #1;
      end
      cfg_valid = '0;
      check("rr_dateline", dateline, 4'hA);
      drain();
      do_reset();

      // Basic dateline write from channel 2
      req(2, 1'b1, 4'd0, 32'h5, 1'b0, 32'h0);
      check("dateline_5", dateline, 4'b0101);

      // LUT entry write and readback
      req(1, 1'b1, 4'd3, 32'h8000_001E, 1'b0, 32'h0);
      check("lut2_valid", lut_valid[2], 1);
      check("lut2_node", lut_node[2*NW +: NW], 6);
      check("lut2_port", lut_port[2*PW +: PW], 3);
      req(0, 1'b0, 4'd3, 32'h0, 1'b0, 32'h8000_001E);
      // Unused write bits are dropped on readback
      req(3, 1'b1, 4'd4, 32'hFFFF_FF05, 1'b0, 32'h0);
      check("lut_valid_23", lut_valid, 8'b0000_1100);
      req(2, 1'b0, 4'd4, 32'h0, 1'b0, 32'h8000_0005);
      drain();

      // Back-pressure: response held, no accepts while rsp_ready is low
      rsp_ready = 1'b0;
      req(0, 1'b0, 4'd0, 32'h0, 1'b0, 32'h5);
      drive(1, 1'b0, 4'd4, 32'h0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("stall_ready", cfg_ready, 0);
         check("stall_rspv", rsp_valid, 1);
         check("stall_chan", rsp_chan, 0);
         check("stall_rdata", rsp_rdata, 32'h5);
      end
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      @(negedge clk);
      check("unstall_ready", cfg_ready, 4'b0010);
      push_exp(1, 1'b0, 32'h8000_0005);
      @(posedge clk);
      #1;
      cfg_valid[1] = 1'b0;
      drain();

      // Error cases leave state untouched
      req(2, 1'b1, 4'd12, 32'hF, 1'b1, 32'h0);
      check("err_dateline", dateline, 4'h5);
      req(0, 1'b0, 4'd15, 32'h0, 1'b1, 32'h0);

      // Control clear
      req(3, 1'b1, 4'd9, 32'h1, 1'b0, 32'h0);
      check("clr_lut_valid", lut_valid, 0);
      check("clr_dateline", dateline, 0);
      req(0, 1'b0, 4'd3, 32'h0, 1'b0, 32'h0000_001E);
      req(1, 1'b0, 4'd9, 32'h0, 1'b0, 32'h0);

      // Lock behaviour (no effect when the feature is not built)
      req(0, 1'b1, 4'd9, 32'h2, 1'b0, 32'h0);
      req(1, 1'b1, 4'd0, 32'hF, L, 32'h0);
      check("lock_dateline", dateline, L ? 4'h0 : 4'hF);
      req(2, 1'b0, 4'd9, 32'h0, 1'b0, L ? 32'h2 : 32'h0);
      req(3, 1'b0, 4'd0, 32'h0, 1'b0, L ? 32'h0 : 32'hF);
      drain();
      do_reset();
      req(1, 1'b1, 4'd0, 32'hF, 1'b0, 32'h0);
      check("unlock_dateline", dateline, 4'hF);
      drain();

      // Range checks on a 3-outport, 6-node instance
      d3_req("d3_port3", 32'h8000_0019, 1'b1);
      check("d3_port3_vld", d3_lut_valid, 0);
      d3_req("d3_node7", 32'h8000_0007, 1'b1);
      check("d3_node7_vld", d3_lut_valid, 0);
      d3_req("d3_ok", 32'h8000_0015, 1'b0);
      check("d3_ok_vld", d3_lut_valid, 8'h01);
      check("d3_ok_port", d3_lut_port[1:0], 2);
      d3_req("d3_inval", 32'h0000_001F, 1'b0);
      check("d3_inval_vld", d3_lut_valid, 0);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/switch_cfg_reg_bank.md
Name: switch_cfg_reg_bank

Overview:
- Configuration register bank for the chiplet switch.
- Holds the per-outport dateline bits and the route lookup table.
- Accepts read/write config requests from NUM_BUFFERS ingress channels, arbitrates them round-robin and executes one per cycle.
- Returns a registered response with error status, and drives the live dateline/route_lut state to the switch routing and VC logic.

Parameters:
- NUM_BUFFERS, 4, number of ingress config request channels.
- NUM_OUTPORTS, 4, number of outports, i.e. dateline bits and legal port values.
- TOTAL_NODES, 8, number of node IDs in the system.
- TABLE_SIZE, 8, number of route LUT entries.
- DATA_W, 32, config data width; must be >= NODE_W+PORT_W+1.
- Derived values:
  - NODE_W = $clog2(TOTAL_NODES)
  - PORT_W = $clog2(NUM_OUTPORTS)
  - ADDR_W = $clog2(TABLE_SIZE+2)
  - CH_W = $clog2(NUM_BUFFERS)

Ports:
- clk  in  1  clock
- n_rst  in  1  asynchronous active-low reset
- cfg_valid  in  NUM_BUFFERS  per-channel request valid
- cfg_we  in  NUM_BUFFERS  per-channel 1=write, 0=read
- cfg_addr  in  NUM_BUFFERS*ADDR_W  per-channel register address
- cfg_wdata  in  NUM_BUFFERS*DATA_W  per-channel write data
- cfg_ready  out  NUM_BUFFERS  per-channel request accepted this cycle
- rsp_valid  out  1  response valid
- rsp_chan  out  CH_W  channel the response belongs to
- rsp_err  out  1  request rejected
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors
- rsp_ready  in  1  response consumer ready
- dateline  out  NUM_OUTPORTS  per-outport dateline bit
- lut_valid  out  TABLE_SIZE  entry valid
- lut_node  out  TABLE_SIZE*NODE_W  entry destination node
- lut_port  out  TABLE_SIZE*PORT_W  entry outport

Behaviour:
- Address map:
  - 0: dateline, in data[NUM_OUTPORTS-1:0].
  - 1..TABLE_SIZE: LUT entry addr-1. Fields: data[NODE_W-1:0]=node, data[NODE_W+PORT_W-1:NODE_W]=port, data[DATA_W-1]=valid.
  - TABLE_SIZE+1: control; a write with data[0]=1 clears all LUT valid bits and the dateline; reads return 0.
  - Anything else: error.
- Reset: all outputs 0, all registers 0, round-robin pointer 0. The reset is asynchronous; any pending response is dropped.
- Arbitration:
  - Round-robin starts from the pointer and searches upward with wrap.
  - On a grant the pointer becomes grant+1 mod NUM_BUFFERS.
  - At most one cfg_ready bit is high per cycle.
- Handshake:
  - A request is accepted when cfg_valid[i] and cfg_ready[i] are both high.
  - Accept is possible only if the response register is empty, or rsp_valid && rsp_ready in the same cycle.
  - Otherwise all cfg_ready bits are 0; the stall happens without a combinational path from cfg_valid to rsp_ready.
- Latency:
  - The write takes effect on the outputs at the clock edge that accepts it, so it is visible the next cycle.
  - rsp_valid rises the cycle after acceptance.
  - Reads return the register value before any write in the same cycle. Only one request is accepted per cycle, so no same-cycle write exists.
- Errors (rsp_err=1, no state change):
  - Address greater than TABLE_SIZE+1.
  - LUT write with valid=1 and port >= NUM_OUTPORTS.
  - LUT write with valid=1 and node >= TOTAL_NODES.
- Response holding: the response is held stable until rsp_ready is seen high. A new accept may overwrite it in the same cycle it is consumed, giving back-to-back throughput of 1 per cycle.
- Unused write data bits are ignored. Readback returns unused bits as 0.
- Channels whose cfg_valid is low are skipped by the arbiter with no penalty cycle.

Optional Feature:
- Macro: SWITCH_CFG_REG_BANK_LOCK_EN.
- When defined:
  - Control register bit 1 is a sticky lock.
  - Once written to 1, every subsequent write to any address returns rsp_err=1 with no state change; reads still succeed.
  - The lock clears only on n_rst.
  - Reading the control register returns the lock in bit 1.
- When undefined:
  - Bit 1 is ignored, writes are never locked, and control reads return 0.

Test Plan:
- Reset, then write addr 0 data 0x5 from channel 2 -> cfg_ready[2] high in that cycle; dateline=4'b0101 next cycle; rsp_valid, rsp_chan=2, rsp_err=0 one cycle after accept.
- Write addr 3 with valid=1, node=6, port=3, then read addr 3 -> lut_valid[2]=1, lut_node[2]=6, lut_port[2]=3; read rsp_rdata=0x8000001E.
- All 4 channels assert cfg_valid continuously with rsp_ready=1 -> grants in order 0,1,2,3,0, one per cycle, rsp_chan follows the same order.
- Hold rsp_ready=0 for 3 cycles with channel 1 valid -> cfg_ready=0 throughout, response stable; rsp_ready=1 -> channel 1 accepted that cycle.
- Write addr 1 port=3 with NUM_OUTPORTS=3, and write addr 12 -> both rsp_err=1, no state change; then control write 0x1 -> all lut_valid=0, dateline=0.
- LOCK_EN defined: control write 0x2, then write addr 0 data 0xF -> rsp_err=1, dateline unchanged; reading addr TABLE_SIZE+1 returns 0x2; after n_rst pulse, the write succeeds.
